// File: rtl/scan_mux_pkg.sv
// Shared mode codes and FSM state encoding for the scanning output multiplexer.
package scan_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_counter.sv
// Modulo-MAX counter; tick marks the cycle in which the count wraps back to zero.
module dwell_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel mux with manual or auto-scan channel select, hold mode and
// a valid/ready output stage. fsm_state exposes the control FSM for observation.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 50000000,
    localparam int SEL_W   = $clog2(CHANNELS),
    localparam int CNT_W   = $clog2(DWELL + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [1:0]                mode,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      sel_err,
    output logic [1:0]                fsm_state
);

    // Handshake: a sample transfers on any cycle where out_valid and out_ready are both 1;
    // while out_valid=1 and out_ready=0, data_out/chan_out/out_valid do not change.

    state_t            state;
    state_t            state_next;
    logic [SEL_W-1:0]  cur_chan;
    logic              manual_mode;
    logic              scan_mode;
    logic              sel_ok;
    logic              tick;
    logic              load;
    logic [WIDTH-1:0]  chan_data [CHANNELS];

    assign manual_mode = (mode == MODE_MANUAL);
    assign scan_mode   = (mode == MODE_SCAN);

    // A full power-of-two channel count leaves no out-of-range select codes.
    if ((1 << SEL_W) == CHANNELS) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_partial
        assign sel_ok = (sel_in < SEL_W'(CHANNELS));
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan_data[k] = data_in[k*WIDTH +: WIDTH];
    end

    // Manual mode keeps the counter cleared so a switch to scan starts a full dwell.
    dwell_counter #(
        .MAX (DWELL),
        .W   (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (manual_mode),
        .en    (scan_mode),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = mode[1] ? ST_HOLD : ST_RUN;
            ST_RUN:  if (mode[1])  state_next = ST_HOLD;
            ST_HOLD: if (!mode[1]) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_chan <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_err <= manual_mode & ~sel_ok;
            if (manual_mode && sel_ok) begin
                cur_chan <= sel_in;
            end else if (tick) begin
                cur_chan <= (cur_chan == SEL_W'(CHANNELS - 1)) ? '0 : cur_chan + 1'b1;
            end
        end
    end

    assign load = (state == ST_RUN) & (~out_valid | out_ready);

    // Outside RUN nothing loads, but a ready consumer still drains the held sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            chan_out  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_out  <= chan_data[cur_chan];
            chan_out  <= cur_chan;
        end else if (state != ST_RUN && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed bench for scan_mux_reg: a 4-channel instance and a 3-channel instance, DWELL=3.
module tb_scan_mux_reg;
    import scan_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data_in;
    logic [1:0] sel_in;
    logic [1:0] mode;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] data_out;
    logic [1:0] chan_out;
    logic       sel_err;
    logic [1:0] fsm_state;

    logic       reset3;
    logic [5:0] data3;
    logic [1:0] sel3;
    logic [1:0] mode3;
    logic       ready3;
    logic       valid3;
    logic [1:0] dout3;
    logic [1:0] chan3;
    logic       err3;
    logic [1:0] fsm3;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    scan_mux_reg #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .sel_err   (sel_err),
        .fsm_state (fsm_state)
    );

    scan_mux_reg #(.WIDTH(2), .CHANNELS(3), .DWELL(3)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .data_in   (data3),
        .sel_in    (sel3),
        .mode      (mode3),
        .out_ready (ready3),
        .out_valid (valid3),
        .data_out  (dout3),
        .chan_out  (chan3),
        .sel_err   (err3),
        .fsm_state (fsm3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] d, input logic [1:0] c);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, ".data"},  32'(data_out),  32'(d));
        check_eq({tag, ".chan"},  32'(chan_out),  32'(c));
    endtask

    initial begin
        logic [1:0] e;
        reset     = 1'b1;
        mode      = MODE_MANUAL;
        sel_in    = 2'd0;
        out_ready = 1'b0;
        data_in   = 8'($urandom);
        reset3    = 1'b1;
        mode3     = MODE_MANUAL;
        sel3      = 2'd0;
        ready3    = 1'b0;
        data3     = 6'($urandom);

        // Reset with random data
        step();
        data_in = 8'($urandom);
        step();
        check_out("reset", 1'b0, 2'd0, 2'd0);
        check_eq("reset.sel_err", 32'(sel_err), 32'd0);
        check_eq("reset.state", 32'(fsm_state), 32'(ST_IDLE));

        // Release: IDLE for one cycle, first load on the second edge
        reset     = 1'b0;
        data_in   = 8'b11_10_01_00;
        out_ready = 1'b1;
        step();
        check_eq("rel1.valid", 32'(out_valid), 32'd0);
        check_eq("rel1.state", 32'(fsm_state), 32'(ST_RUN));
        step();
        check_out("rel2", 1'b1, 2'b00, 2'd0);

        // Manual select: sel_in -> chan_out in two cycles
        sel_in = 2'd2;
        step();
        check_out("man1", 1'b1, 2'b00, 2'd0);
        step();
        check_out("man2", 1'b1, 2'b10, 2'd2);
        data_in = 8'b00_01_10_11;
        step();
        check_out("man_data", 1'b1, 2'b01, 2'd2);
        data_in = 8'b11_10_01_00;
        sel_in  = 2'd0;
        step();
        step();
        check_out("man_ch0", 1'b1, 2'b00, 2'd0);

        // Scan from channel 0, sel_in ignored
        mode   = MODE_SCAN;
        sel_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) exp_q.push_back(2'(i));
        end
        exp_q.push_back(2'd0);
        for (int i = 0; i < 13; i++) begin
            step();
            e = exp_q.pop_front();
            check_out($sformatf("scan%0d", i), 1'b1, e, e);
        end

        // Backpressure: outputs frozen while the scan keeps moving
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_out($sformatf("stall%0d", i), 1'b1, 2'b00, 2'd0);
        end
        out_ready = 1'b1;
        step();
        check_out("unstall1", 1'b1, 2'b10, 2'd2);
        step();
        check_out("unstall2", 1'b1, 2'b11, 2'd3);

        // Hold: the mode-change cycle still loads from RUN
        mode    = MODE_HOLD;
        data_in = 8'b00_01_10_11;
        step();
        check_out("hold_enter", 1'b1, 2'b00, 2'd3);
        check_eq("hold.state", 32'(fsm_state), 32'(ST_HOLD));
        out_ready = 1'b0;
        data_in   = 8'b11_11_11_11;
        step();
        step();
        check_out("hold_frozen", 1'b1, 2'b00, 2'd3);
        out_ready = 1'b1;
        step();
        check_out("hold_consume", 1'b0, 2'b00, 2'd3);
        out_ready = 1'b0;
        step();
        check_eq("hold_idle.valid", 32'(out_valid), 32'd0);

        // Back to manual: RUN next edge, load on the following one
        mode      = MODE_MANUAL;
        sel_in    = 2'd1;
        out_ready = 1'b1;
        data_in   = 8'b11_10_01_00;
        step();
        check_eq("resume1.valid", 32'(out_valid), 32'd0);
        check_eq("resume1.state", 32'(fsm_state), 32'(ST_RUN));
        step();
        check_out("resume2", 1'b1, 2'b01, 2'd1);

        // Reset mid-scan during a stall
        mode = MODE_SCAN;
        step();
        step();
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_out("midreset", 1'b0, 2'b00, 2'd0);
        check_eq("midreset.state", 32'(fsm_state), 32'(ST_IDLE));
        reset     = 1'b0;
        out_ready = 1'b1;
        data_in   = 8'b00_00_00_11;
        step();
        step();
        check_out("postreset", 1'b1, 2'b11, 2'd0);

        // Three-channel instance: out-of-range select and non-power-of-two wrap
        reset3 = 1'b0;
        data3  = 6'b10_01_11;
        sel3   = 2'd2;
        ready3 = 1'b1;
        step();
        step();
        check_eq("r3_load.chan", 32'(chan3), 32'd2);
        check_eq("r3_load.data", 32'(dout3), 32'(2'b10));
        sel3 = 2'd3;
        step();
        check_eq("r3_err.sel_err", 32'(err3), 32'd1);
        check_eq("r3_err.chan", 32'(chan3), 32'd2);
        sel3 = 2'd1;
        step();
        check_eq("r3_err_end.sel_err", 32'(err3), 32'd0);
        check_eq("r3_err_end.chan", 32'(chan3), 32'd2);
        step();
        check_eq("r3_ch1.chan", 32'(chan3), 32'd1);
        check_eq("r3_ch1.data", 32'(dout3), 32'(2'b01));

        mode3 = MODE_SCAN;
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 7; i++) begin
            step();
            e = exp_q.pop_front();
            check_eq($sformatf("r3_scan%0d.chan", i), 32'(chan3), 32'(e));
            check_eq($sformatf("r3_scan%0d.valid", i), 32'(valid3), 32'd1);
        end
        check_eq("r3_scan_end.data", 32'(dout3), 32'(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
